// File: rtl/ps2_pkg.sv
// Shared scancode constants, key indices and receiver state type for the PS/2 key decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [2:0] {
    K_J1_UP, K_J1_DOWN, K_J1_LEFT, K_J1_RIGHT,
    K_J2_UP, K_J2_DOWN, K_J2_LEFT, K_J2_RIGHT
  } key_e;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  typedef struct packed {
    logic hit;
    key_e key;
  } key_hit_t;

  // The extended flag is part of the key: keypad codes and E0-prefixed WASD never match.
  function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
    key_hit_t r;
    r.hit = 1'b1;
    r.key = K_J1_UP;
    case ({ext, code})
      {1'b0, SC_W}:     r.key = K_J1_UP;
      {1'b0, SC_S}:     r.key = K_J1_DOWN;
      {1'b0, SC_A}:     r.key = K_J1_LEFT;
      {1'b0, SC_D}:     r.key = K_J1_RIGHT;
      {1'b1, SC_UP}:    r.key = K_J2_UP;
      {1'b1, SC_DOWN}:  r.key = K_J2_DOWN;
      {1'b1, SC_LEFT}:  r.key = K_J2_LEFT;
      {1'b1, SC_RIGHT}: r.key = K_J2_RIGHT;
      default:          r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronizers, clock glitch filter, falling-edge strobe,
// 11-bit frame FSM with odd-parity/stop checks and a partial-frame timeout.
module ps2_rx import ps2_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_s, data_s;
  logic          filt_q, filt_prev_q;
  logic [FW-1:0] filt_cnt_q;
  logic          strobe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_s == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q     <= clk_s;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  assign strobe = filt_prev_q & ~filt_q;

  rx_state_e     state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] tcnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tcnt_q   <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (strobe) begin
        tcnt_q <= '0;
        case (state_q)
          IDLE: begin
            if (!data_s) begin
              state_q  <= DATA;
              bitcnt_q <= '0;
            end
          end
          DATA: begin
            shift_q  <= {data_s, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            parity_q <= data_s;
            state_q  <= STOP;
          end
          STOP: begin
            if (data_s && (^{shift_q, parity_q})) begin
              rx_byte  <= shift_q;
              rx_valid <= 1'b1;
            end else begin
              rx_error <= 1'b1;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q == IDLE) begin
        tcnt_q <= '0;
      end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_q  <= IDLE;
        tcnt_q   <= '0;
        rx_error <= 1'b1;
      end else begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keys_decoder.sv
// PS/2 set-2 key decoder: tracks E0/F0 prefixes and holds one level bit per player key.
module ps2_keys_decoder import ps2_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       j1_up,
  output logic       j1_down,
  output logic       j1_left,
  output logic       j1_right,
  output logic       j2_up,
  output logic       j2_down,
  output logic       j2_left,
  output logic       j2_right,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_error
);

  logic       ext_q, brk_q;
  logic [7:0] keys_q;
  key_hit_t   lk;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FILTER_LEN    (FILTER_LEN)
  ) u_rx (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_error(rx_error)
  );

  assign lk = key_lookup(ext_q, rx_byte);

  // Prefix flags OR-accumulate so F0 E0 xx behaves like E0 F0 xx.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      keys_q <= '0;
    end else if (rx_error) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_q <= 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_q <= 1'b1;
      end else begin
        if (lk.hit) keys_q[lk.key] <= ~brk_q;
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  assign j1_up    = keys_q[K_J1_UP];
  assign j1_down  = keys_q[K_J1_DOWN];
  assign j1_left  = keys_q[K_J1_LEFT];
  assign j1_right = keys_q[K_J1_RIGHT];
  assign j2_up    = keys_q[K_J2_UP];
  assign j2_down  = keys_q[K_J2_DOWN];
  assign j2_left  = keys_q[K_J2_LEFT];
  assign j2_right = keys_q[K_J2_RIGHT];

endmodule

// File: tb/tb_ps2_keys_decoder.sv
// Directed bench for ps2_keys_decoder: bit-banged PS/2 frames with hand-computed key states.
module tb_ps2_keys_decoder;

  localparam int TIMEOUT = 1000;
  localparam int FILT    = 4;
  localparam int HALF    = 40;
  // Clock fall to registered rx_valid: 2 sync stages, FILT filter samples, 1 FSM edge.
  localparam int LAT     = FILT + 3;

  logic       clk = 1'b0;
  logic       reset_n, ps2_clk, ps2_data;
  logic       j1_up, j1_down, j1_left, j1_right, j2_up, j2_down, j2_left, j2_right;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_error;
  logic [7:0] keys;

  int checks = 0, passed = 0;
  int n_valid = 0, n_err = 0, n_drop = 0;
  int valid_at;
  logic watch = 1'b0;
  logic [7:0] keys_v, keys_n;

  ps2_keys_decoder #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .FILTER_LEN    (FILT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .j1_up   (j1_up),
    .j1_down (j1_down),
    .j1_left (j1_left),
    .j1_right(j1_right),
    .j2_up   (j2_up),
    .j2_down (j2_down),
    .j2_left (j2_left),
    .j2_right(j2_right),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_error(rx_error)
  );

  assign keys = {j2_right, j2_left, j2_down, j2_up, j1_right, j1_left, j1_down, j1_up};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid) n_valid++;
      if (rx_error) n_err++;
      if (watch && keys[3:2] != 2'b11) n_drop++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want $finish before 200000 cycles");
    $fatal(1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic last);
    ps2_data = b;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    if (last) begin
      valid_at = 0;
      for (int n = 1; n <= HALF; n++) begin
        @(posedge clk);
        #1;
        if (rx_valid && valid_at == 0) begin
          valid_at = n;
          keys_v = keys;
        end else if (valid_at != 0 && n == valid_at + 1) begin
          keys_n = keys;
        end
      end
    end else begin
      wait_clks(HALF);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], i == 10);
    ps2_data = 1'b1;
    wait_clks(20);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_clks(3);
    checks++; if (keys !== 8'h00) $display("FAIL reset_keys: got %h want 00", keys); else passed++;
    checks++; if (rx_byte !== 8'h00) $display("FAIL reset_byte: got %h want 00", rx_byte); else passed++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else passed++;
    checks++; if (rx_error !== 1'b0) $display("FAIL reset_error: got %b want 0", rx_error); else passed++;
    reset_n = 1'b1;
    wait_clks(10);
  endtask

  task automatic test_make_break;
    int v0;
    send_frame(8'h1D, 1'b0);
    checks++; if (valid_at !== LAT) $display("FAIL valid_latency: got %0d want %0d", valid_at, LAT); else passed++;
    checks++; if (keys_v !== 8'h00) $display("FAIL keys_in_valid_cycle: got %h want 00", keys_v); else passed++;
    checks++; if (keys_n !== 8'h01) $display("FAIL keys_after_valid: got %h want 01", keys_n); else passed++;
    checks++; if (rx_byte !== 8'h1D) $display("FAIL byte_1d: got %h want 1d", rx_byte); else passed++;
    v0 = n_valid;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b0);
    checks++; if (keys !== 8'h00) $display("FAIL break_w: got %h want 00", keys); else passed++;
    checks++; if (n_valid - v0 !== 2) $display("FAIL valid_count: got %0d want 2", n_valid - v0); else passed++;
  endtask

  task automatic test_extended;
    send_frame(8'h75, 1'b0);
    checks++; if (keys !== 8'h00) $display("FAIL keypad_75: got %h want 00", keys); else passed++;
    send_frame(8'hE0, 1'b0); send_frame(8'h75, 1'b0);
    checks++; if (keys !== 8'h10) $display("FAIL make_up: got %h want 10", keys); else passed++;
    send_frame(8'hE0, 1'b0); send_frame(8'h1D, 1'b0);
    checks++; if (keys !== 8'h10) $display("FAIL ext_w: got %h want 10", keys); else passed++;
    send_frame(8'hE0, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h75, 1'b0);
    checks++; if (keys !== 8'h00) $display("FAIL break_up: got %h want 00", keys); else passed++;
    send_frame(8'hE0, 1'b0); send_frame(8'h74, 1'b0);
    checks++; if (keys !== 8'h80) $display("FAIL make_right: got %h want 80", keys); else passed++;
    send_frame(8'hF0, 1'b0); send_frame(8'hE0, 1'b0); send_frame(8'h74, 1'b0);
    checks++; if (keys !== 8'h00) $display("FAIL f0_e0_order: got %h want 00", keys); else passed++;
  endtask

  task automatic test_parity_error;
    int e0, v0;
    e0 = n_err; v0 = n_valid;
    send_frame(8'h1C, 1'b1);
    checks++; if (n_err - e0 !== 1) $display("FAIL parity_err_count: got %0d want 1", n_err - e0); else passed++;
    checks++; if (n_valid !== v0) $display("FAIL parity_no_valid: got %0d want %0d", n_valid, v0); else passed++;
    checks++; if (keys !== 8'h00) $display("FAIL parity_keys: got %h want 00", keys); else passed++;
    checks++; if (rx_byte !== 8'h74) $display("FAIL parity_byte_kept: got %h want 74", rx_byte); else passed++;
    send_frame(8'hE0, 1'b0); send_frame(8'h33, 1'b1); send_frame(8'h75, 1'b0);
    checks++; if (keys !== 8'h00) $display("FAIL error_clears_ext: got %h want 00", keys); else passed++;
    send_frame(8'h1C, 1'b0);
    checks++; if (keys !== 8'h04) $display("FAIL make_a: got %h want 04", keys); else passed++;
  endtask

  task automatic test_timeout;
    int e0, v0, err_at;
    logic [5:0] bits;
    e0 = n_err; v0 = n_valid;
    bits = 6'b011010;
    for (int i = 0; i < 5; i++) send_bit(bits[i], 1'b0);
    ps2_data = bits[5];
    wait_clks(HALF);
    ps2_clk = 1'b0;
    err_at = 0;
    for (int n = 1; n <= TIMEOUT + LAT + 20; n++) begin
      @(posedge clk);
      #1;
      if (n == HALF) begin ps2_clk = 1'b1; ps2_data = 1'b1; end
      if (rx_error && err_at == 0) err_at = n;
    end
    checks++; if (err_at !== TIMEOUT + LAT) $display("FAIL timeout_cycle: got %0d want %0d", err_at, TIMEOUT + LAT); else passed++;
    checks++; if (n_err - e0 !== 1) $display("FAIL timeout_err_count: got %0d want 1", n_err - e0); else passed++;
    checks++; if (n_valid !== v0) $display("FAIL timeout_no_valid: got %0d want %0d", n_valid, v0); else passed++;
    send_frame(8'h23, 1'b0);
    checks++; if (keys !== 8'h0C) $display("FAIL after_timeout_d: got %h want 0c", keys); else passed++;
    checks++; if (rx_byte !== 8'h23) $display("FAIL after_timeout_byte: got %h want 23", rx_byte); else passed++;
  endtask

  task automatic test_typematic;
    n_drop = 0;
    watch = 1'b1;
    repeat (5) send_frame(8'h1C, 1'b0);
    watch = 1'b0;
    checks++; if (n_drop !== 0) $display("FAIL typematic_glitch: got %0d want 0", n_drop); else passed++;
    checks++; if (keys !== 8'h0C) $display("FAIL typematic_keys: got %h want 0c", keys); else passed++;
    send_frame(8'hF0, 1'b0); send_frame(8'h1C, 1'b0);
    checks++; if (keys !== 8'h08) $display("FAIL release_a_only: got %h want 08", keys); else passed++;
  endtask

  task automatic test_reset_mid;
    send_frame(8'h1B, 1'b0);
    checks++; if (keys !== 8'h0A) $display("FAIL make_s: got %h want 0a", keys); else passed++;
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    reset_n = 1'b0;
    #2;
    checks++; if (keys !== 8'h00) $display("FAIL midreset_keys: got %h want 00", keys); else passed++;
    checks++; if (rx_byte !== 8'h00) $display("FAIL midreset_byte: got %h want 00", rx_byte); else passed++;
    wait_clks(3);
    checks++; if ({rx_valid, rx_error} !== 2'b00) $display("FAIL midreset_pulses: got %b want 00", {rx_valid, rx_error}); else passed++;
    reset_n = 1'b1; ps2_data = 1'b1;
    wait_clks(10);
    send_frame(8'h1B, 1'b0);
    checks++; if (keys !== 8'h02) $display("FAIL post_reset_s: got %h want 02", keys); else passed++;
    checks++; if (rx_byte !== 8'h1B) $display("FAIL post_reset_byte: got %h want 1b", rx_byte); else passed++;
  endtask

  task automatic test_glitch;
    int e0, v0;
    e0 = n_err; v0 = n_valid;
    ps2_data = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    @(posedge clk);
    #1;
    ps2_clk = 1'b1;
    wait_clks(HALF);
    ps2_data = 1'b1;
    wait_clks(HALF);
    send_frame(8'h1D, 1'b0);
    checks++; if (rx_byte !== 8'h1D) $display("FAIL glitch_byte: got %h want 1d", rx_byte); else passed++;
    checks++; if (keys !== 8'h03) $display("FAIL glitch_keys: got %h want 03", keys); else passed++;
    checks++; if (n_err !== e0) $display("FAIL glitch_err: got %0d want %0d", n_err, e0); else passed++;
    checks++; if (n_valid - v0 !== 1) $display("FAIL glitch_valid: got %0d want 1", n_valid - v0); else passed++;
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_parity_error();
    test_timeout();
    test_typematic();
    test_reset_mid();
    test_glitch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
